// File: rtl/sd_defs_pkg.sv
// sd_defs_pkg: shared constants and types for the SD command engine.
// Response-length codes, CRC7 polynomial and FSM state encoding.
package sd_defs_pkg;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_48   = 2'd1;
  localparam logic [1:0] RESP_136  = 2'd2;
  localparam logic [1:0] RESP_RSVD = 2'd3;

  localparam logic [6:0] CRC7_POLY   = 7'h09;
  localparam int         NCR_DEFAULT = 64;
  localparam logic [7:0] TX_LAST     = 8'd48;
  localparam logic [7:0] CRC_LO      = 8'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT_RSP,
    ST_RX,
    ST_FIN
  } state_e;

  function automatic logic [6:0] crc7_step(
    input logic [6:0] c,
    input logic       b
  );
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial MSB-first CRC7 (x^7+x^3+1), zero initial value.
// Synchronous clear has priority over enable.
module sd_crc7
  import sd_defs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/sd_cmd_host.sv
// sd_cmd_host: SD host command-line engine.
// Sends a 48-bit command, then captures and checks the card response.
module sd_cmd_host
  import sd_defs_pkg::*;
#(
  parameter int NCR_MAX = NCR_DEFAULT
) (
  input  logic         sdClk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_len,
  input  logic         check_crc,
  input  logic         check_idx,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         busy,
  output logic         done,
  output logic [127:0] resp,
  output logic         timeout,
  output logic         crc_err,
  output logic         idx_err,
  output logic         stop_err
);

  state_e         state;
  state_e         state_nxt;
  logic [135:0]   sr;
  logic [7:0]     bit_cnt;
  logic [6:0]     wait_cnt;
  logic [5:0]     idx_q;
  logic [1:0]     len_q;
  logic           crc_on;
  logic           idx_on;

  logic           accept;
  logic           long_rsp;
  logic           wait_done;
  logic [7:0]     rx_last;
  logic [7:0]     rx_top;
  logic [7:0]     crc_hi;
  logic [7:0]     fb_idx;
  logic [2:0]     crc_sel;
  logic           tx_crc_en;
  logic           rx_crc_en;
  logic [6:0]     tx_crc;
  logic [6:0]     rx_crc;

  assign busy = (state != ST_IDLE) && (state != ST_FIN);
  assign done = (state == ST_FIN);

  assign accept    = start && !busy;
  assign long_rsp  = (len_q == RESP_136);
  assign wait_done = (wait_cnt == 7'(NCR_MAX));

  // fb_idx is the frame bit position of the bit sampled this cycle
  assign rx_last = long_rsp ? 8'd135 : 8'd47;
  assign rx_top  = long_rsp ? 8'd134 : 8'd46;
  assign crc_hi  = long_rsp ? 8'd127 : 8'd46;
  assign fb_idx  = rx_top - bit_cnt;
  assign crc_sel = 3'(8'd46 - bit_cnt);

  assign tx_crc_en = (state == ST_TX) && (bit_cnt < 8'd40);
  assign rx_crc_en = (state == ST_RX) && (bit_cnt != rx_last)
                   && (fb_idx >= CRC_LO) && (fb_idx <= crc_hi);

  sd_crc7 u_tx_crc (
    .clk    (sdClk),
    .rst    (rst),
    .clear  (accept),
    .enable (tx_crc_en),
    .din    (sr[135]),
    .crc    (tx_crc)
  );

  sd_crc7 u_rx_crc (
    .clk    (sdClk),
    .rst    (rst),
    .clear  (accept),
    .enable (rx_crc_en),
    .din    (cmd_in),
    .crc    (rx_crc)
  );

  always_ff @(posedge sdClk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_FIN: begin
        state_nxt = start ? ST_TX : ST_IDLE;
      end
      ST_TX: begin
        if (bit_cnt == TX_LAST)
          state_nxt = (len_q == RESP_NONE) ? ST_FIN : ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (wait_done)   state_nxt = ST_FIN;
        else if (!cmd_in) state_nxt = ST_RX;
      end
      ST_RX: begin
        if (bit_cnt == rx_last) state_nxt = ST_FIN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sdClk) begin
    if (rst) begin
      cmd_out  <= 1'b1;
      cmd_oe   <= 1'b0;
      resp     <= '0;
      timeout  <= 1'b0;
      crc_err  <= 1'b0;
      idx_err  <= 1'b0;
      stop_err <= 1'b0;
      sr       <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      idx_q    <= '0;
      len_q    <= RESP_NONE;
      crc_on   <= 1'b0;
      idx_on   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_FIN: begin
          if (start) begin
            idx_q    <= cmd_index;
            len_q    <= (resp_len == RESP_RSVD) ? RESP_NONE : resp_len;
            crc_on   <= check_crc;
            idx_on   <= check_idx;
            sr       <= {2'b01, cmd_index, cmd_arg, 96'd0};
            bit_cnt  <= '0;
            wait_cnt <= '0;
            resp     <= '0;
            timeout  <= 1'b0;
            crc_err  <= 1'b0;
            idx_err  <= 1'b0;
            stop_err <= 1'b0;
          end
        end
        ST_TX: begin
          bit_cnt <= bit_cnt + 8'd1;
          if (bit_cnt < 8'd40) begin
            cmd_oe  <= 1'b1;
            cmd_out <= sr[135];
            sr      <= {sr[134:0], 1'b0};
          end else if (bit_cnt < 8'd47) begin
            cmd_oe  <= 1'b1;
            cmd_out <= tx_crc[crc_sel];
          end else if (bit_cnt == 8'd47) begin
            cmd_oe  <= 1'b1;
            cmd_out <= 1'b1;
          end else begin
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          if (wait_done) begin
            timeout <= 1'b1;
          end else if (!cmd_in) begin
            sr      <= '0;
            bit_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 7'd1;
          end
        end
        ST_RX: begin
          if (bit_cnt == rx_last) begin
            stop_err <= ~sr[0];
            crc_err  <= crc_on && (sr[7:1] != rx_crc);
            idx_err  <= idx_on && (len_q == RESP_48)
                        && (sr[45:40] != idx_q);
            resp     <= long_rsp ? sr[127:0] : {90'd0, sr[45:8]};
          end else begin
            sr      <= {sr[134:0], cmd_in};
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
